// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer
// carrying instruction/address, with flush, hold-driven stall and a registered interrupt flag.
module if_id_queue #(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    AW       = 32,
  parameter int unsigned    IW       = 32,
  parameter int unsigned    INTW     = 8,
  parameter int unsigned    HOLD_W   = 3,
  parameter int unsigned    HOLD_IF  = 1,
  parameter logic [IW-1:0]  NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IW-1:0]              inst_i,
  input  logic [AW-1:0]              inst_addr_i,
  input  logic                       inst_valid_i,
  input  logic [INTW-1:0]            int_flag_i,
  input  logic [HOLD_W-1:0]          hold_flag_i,
  input  logic                       flush_i,
  output logic                       ready_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [IW-1:0]              inst_o,
  output logic [AW-1:0]              inst_addr_o,
  output logic                       inst_valid_o,
  output logic [INTW-1:0]            int_flag_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_IF);
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  logic [IW-1:0]   inst_mem_q [DEPTH];
  logic [AW-1:0]   addr_mem_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [INTW-1:0] int_flag_q, int_flag_d;

  logic empty, full, stall, push, pop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    stall = (hold_flag_i >= HOLD_LVL);
    push  = inst_valid_i && !full && !flush_i;
    pop   = !empty && !stall && !flush_i;
  end

  // Push decision uses pre-pop occupancy, so a full queue never refills in the popping cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      int_flag_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (!stall) int_flag_d = int_flag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      int_flag_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      inst_mem_q[wr_ptr_q] <= inst_i;
      addr_mem_q[wr_ptr_q] <= inst_addr_i;
    end
  end

  always_comb begin
    ready_o      = !full;
    count_o      = count_q;
    int_flag_o   = int_flag_q;
    inst_o       = NOP_INST;
    inst_addr_o  = '0;
    inst_valid_o = 1'b0;
    if (!empty) begin
      inst_o       = inst_mem_q[rd_ptr_q];
      inst_addr_o  = addr_mem_q[rd_ptr_q];
      inst_valid_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed steps followed by random traffic, all checked
// against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HOLD_IF = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, inst_addr_i;
  logic        inst_valid_i;
  logic [7:0]  int_flag_i;
  logic [2:0]  hold_flag_i;
  logic        flush_i;
  logic        ready_o;
  logic [2:0]  count_o;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;
  logic [7:0]  int_flag_o;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH(DEPTH), .AW(32), .IW(32), .INTW(8), .HOLD_W(3),
    .HOLD_IF(HOLD_IF), .NOP_INST(32'h00000013)
  ) u_dut (
    .clk(clk), .rst(rst_n),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
    .int_flag_i(int_flag_i), .hold_flag_i(hold_flag_i), .flush_i(flush_i),
    .ready_o(ready_o), .count_o(count_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
    .int_flag_o(int_flag_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_int;
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    chk("count", 64'(count_o), 64'(n));
    chk("ready", 64'(ready_o), 64'(n != DEPTH));
    chk("valid", 64'(inst_valid_o), 64'(n != 0));
    chk("inst",  64'(inst_o), (n == 0) ? 64'h13 : 64'(q[0].inst));
    chk("addr",  64'(inst_addr_o), (n == 0) ? 64'h0 : 64'(q[0].addr));
    chk("intf",  64'(int_flag_o), 64'(m_int));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic [7:0] f,
                      input logic [2:0] h, input logic fl);
    bit   stl, was_full, do_pop, do_push;
    ent_t e;
    rst_n = r; inst_valid_i = v; inst_i = ins; inst_addr_i = a;
    int_flag_i = f; hold_flag_i = h; flush_i = fl;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_int = '0;
    end else if (fl) begin
      q.delete();
      m_int = '0;
    end else begin
      stl      = (int'(h) >= int'(HOLD_IF));
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && !stl;
      do_push  = v && !was_full;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.inst = ins;
        e.addr = a;
        q.push_back(e);
      end
      if (!stl) m_int = f;
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  initial begin
    m_int = '0;

    // reset held for two cycles while fetch offers instructions
    step(1'b0, 1'b1, mk(32'h40), 32'h40, 8'h00, 3'd0, 1'b0);
    step(1'b0, 1'b1, mk(32'h44), 32'h44, 8'h00, 3'd0, 1'b0);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_inst",  64'(inst_o),  64'h13);
    chk("rst_ready", 64'(ready_o), 64'h1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0);

    // streaming with no stall: one entry in flight, one cycle latency
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, mk(32'(i * 4)), 32'(i * 4), 8'h00, 3'd0, 1'b0);
      chk("stream_addr", 64'(inst_addr_o), 64'(i * 4));
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0);

    // fill under hold, fifth push dropped, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, mk(32'(i * 4)), 32'(i * 4), 8'h00, 3'd1, 1'b0);
    chk("full_ready", 64'(ready_o), 64'h0);
    chk("full_count", 64'(count_o), 64'h4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 64'(inst_addr_o), 64'(i * 4));
      step(1'b1, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0);
    end
    chk("drain_empty", 64'(inst_valid_o), 64'h0);

    // six more pushes under hold/release so the pointers wrap
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, mk(32'h100 + 32'(i * 4)), 32'h100 + 32'(i * 4), 8'h00,
           (i < 3) ? 3'd1 : 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 32'h0, 32'h0, 8'h00, 3'd0, 1'b0);

    // full with a pop and a simultaneous offer: no refill
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, mk(32'h200 + 32'(i * 4)), 32'h200 + 32'(i * 4), 8'h5A, 3'd0 + 3'd1, 1'b0);
    step(1'b1, 1'b1, mk(32'h300), 32'h300, 8'h5A, 3'd0, 1'b0);
    chk("fullpop_count", 64'(count_o), 64'h3);
    chk("fullpop_intf",  64'(int_flag_o), 64'h5A);

    // flush with push offered and no stall
    step(1'b1, 1'b1, mk(32'h400), 32'h400, 8'h77, 3'd0, 1'b1);
    chk("flush_count", 64'(count_o), 64'h0);
    chk("flush_valid", 64'(inst_valid_o), 64'h0);
    chk("flush_intf",  64'(int_flag_o), 64'h0);

    // interrupt flag held under stall, loaded after release
    step(1'b1, 1'b0, 32'h0, 32'h0, 8'h5A, 3'd0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 8'h01, 3'd2, 1'b0);
    chk("intf_hold", 64'(int_flag_o), 64'h5A);
    step(1'b1, 1'b0, 32'h0, 32'h0, 8'h01, 3'd0, 1'b0);
    chk("intf_load", 64'(int_flag_o), 64'h01);

    // random traffic including drops, flushes, stalls and mid-run reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [2:0]  h;
      a = $urandom() & 32'hFFFF_FFFC;
      h = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom(), a,
           8'($urandom()), h, ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Decouples ROM/bus fetch latency from decode stalls, so fetch can run ahead while decode is held.
- Carries instruction, address and interrupt flag per entry, with flush support for branches and traps and a ready/occupancy interface back to the PC generator.
- Sits between pc_reg/ROM and id.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- AW, 32, instruction address width.
- IW, 32, instruction width.
- INTW, 8, interrupt flag width.
- HOLD_W, 3, hold flag bus width.
- HOLD_IF, 1, hold level at or above which the decode side is stalled.
- NOP_INST, 32'h00000013, instruction presented when the queue is empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- inst_i  in  IW  fetched instruction.
- inst_addr_i  in  AW  address of inst_i.
- inst_valid_i  in  1  inst_i/inst_addr_i valid this cycle.
- int_flag_i  in  INTW  interrupt flag from the interrupt controller.
- hold_flag_i  in  HOLD_W  pipeline hold level from ctrl.
- flush_i  in  1  discard all queued instructions (jump/trap).
- ready_o  out  1  queue can accept an instruction this cycle (= !full).
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- inst_o  out  IW  head instruction to decode.
- inst_addr_o  out  AW  head address.
- inst_valid_o  out  1  head is valid.
- int_flag_o  out  INTW  registered interrupt flag to decode.

Behaviour:
- Reset:
  - Applied while rst==0, sampled at the clk edge.
  - wr_ptr, rd_ptr and count cleared to 0.
  - Outputs: inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, int_flag_o=0, ready_o=1, count_o=0.
  - Storage array contents are not reset.
  - Reset asserted mid-operation discards all entries on that edge.
- Storage: circular buffer with pointers of width $clog2(DEPTH), wrapping naturally at DEPTH-1 -> 0. count tracks occupancy from 0 to DEPTH.
- Derived signals:
  - empty = (count==0); full = (count==DEPTH).
  - stall = (hold_flag_i >= HOLD_IF), unsigned compare.
- Push when inst_valid_i && !full && !flush_i.
  - Writes {inst_i, inst_addr_i} at wr_ptr; wr_ptr++.
  - Input arriving while full is dropped. The fetch side must honour ready_o.
- Pop when !empty && !stall && !flush_i; rd_ptr++.
  - The head being presented this cycle is the one consumed.
- Occupancy update: push-only gives count+1; pop-only gives count-1; push+pop leaves count unchanged.
  - Full with a pop: ready_o is still 0 that cycle, so there is no same-cycle refill. Occupancy drops to DEPTH-1 next cycle.
- Head outputs are combinational from the head entry:
  - Not empty: inst_o=mem[rd_ptr], inst_addr_o=addr[rd_ptr], inst_valid_o=1.
  - Empty: NOP_INST, 0, 0.
- Latency: there is no empty bypass. An instruction pushed at edge N is visible on the outputs after edge N (1 cycle).
- Stall holds rd_ptr. Head outputs stay stable while pushes continue up to full.
- Flush:
  - On the edge with flush_i=1: wr_ptr=rd_ptr=0 and count=0, regardless of a simultaneous push, pop or stall.
  - The next cycle presents NOP with valid 0.
  - Flush has priority over everything except reset.
- int_flag_o is a register:
  - Loads int_flag_i each edge when !stall.
  - Holds when stall.
  - Clears to 0 on flush_i.
- ready_o and count_o are combinational from count only, never from inputs, so there is no combinational path from inst_valid_i.

Test Plan:
- Reset: drive rst=0 for 2 cycles with inst_valid_i=1 -> count_o=0, inst_valid_o=0, inst_o=32'h13, ready_o=1 after release.
- Stream with DEPTH=4 and no stall: push addrs 0x0,0x4,0x8 on consecutive cycles -> each appears on inst_addr_o exactly 1 cycle after its push, in order; count_o stays at 1.
- Fill and wrap: hold_flag_i=1 while pushing 5 instructions -> the first 4 are stored, count_o=4 and ready_o=0, the 5th is dropped. Release hold -> 0x0,0x4,0x8,0xC drain in order. Push 6 more -> the pointers wrap and order is preserved.
- Full with pop: queue full, hold released and inst_valid_i=1 in the same cycle -> head popped, new input not accepted, count_o=3 next cycle.
- Flush mid-stream: count_o=3 with flush_i=1, inst_valid_i=1 and stall=0 all in one cycle -> next cycle count_o=0, inst_valid_o=0 and int_flag_o=0; the input of that cycle is lost.
- Interrupt flag: int_flag_i=8'h01 during hold_flag_i=2 -> int_flag_o keeps its old value. Drop hold -> int_flag_o=8'h01 after one edge.
